// File: rtl/fetch_sequencer.sv
// Fetch sequencer: owns the architectural PC, issues req/ack fetches to
// instruction memory, buffers one fetched word for decode and handles
// redirects, including killing a fetch that is already in flight.
module fetch_sequencer #(
  parameter logic [31:0] RESET_PC = 32'h0000_3000
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_target,
  input  logic        dec_ready,
  input  logic        stall,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic        instr_valid,
  output logic [31:0] instr,
  output logic [31:0] instr_pc,
  output logic [31:0] pc_plus_4,
  output logic        addr_err
);

  typedef enum logic [1:0] {
    BOOT  = 2'd0,
    FETCH = 2'd1,
    HOLD  = 2'd2
  } state_t;

  // Word-align a redirect target by clearing the two low bits.
  function automatic logic [31:0] align_word(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

  state_t      state_r, state_s;
  logic [31:0] pc_r, pc_s;
  logic        kill_r, kill_s;
  logic [31:0] pend_r, pend_s;
  logic        instr_valid_r, instr_valid_s;
  logic [31:0] instr_r, instr_s;
  logic [31:0] instr_pc_r, instr_pc_s;
  logic        addr_err_r, addr_err_s;
  logic        imem_req_r;
  logic [31:0] imem_addr_r;
  logic [31:0] redir_tgt_s;
  logic        redir_mis_s;

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r <= BOOT;
    end else begin
      state_r <= state_s;
    end
  end

  // Next-state and next-datapath decode; redirect beats consume beats hold.
  always_comb begin
    state_s       = state_r;
    pc_s          = pc_r;
    kill_s        = kill_r;
    pend_s        = pend_r;
    instr_valid_s = instr_valid_r;
    instr_s       = instr_r;
    instr_pc_s    = instr_pc_r;
    addr_err_s    = 1'b0;
    redir_tgt_s   = align_word(redirect_target);
    redir_mis_s   = (redirect_target[1:0] != 2'b00);
    case (state_r)
      BOOT: begin
        state_s = FETCH;
      end
      FETCH: begin
        if (imem_ack) begin
          if (redirect_valid) begin
            // Returning word belongs to the old path: drop it, go to new target.
            pc_s       = redir_tgt_s;
            kill_s     = 1'b0;
            addr_err_s = redir_mis_s;
          end else if (kill_r) begin
            pc_s   = pend_r;
            kill_s = 1'b0;
          end else begin
            instr_s       = imem_rdata;
            instr_pc_s    = pc_r;
            instr_valid_s = 1'b1;
            pc_s          = pc_r + 32'd4;
            state_s       = HOLD;
          end
        end else if (redirect_valid) begin
          // Address must stay stable until the ack, so park the target.
          pend_s     = redir_tgt_s;
          kill_s     = 1'b1;
          addr_err_s = redir_mis_s;
        end else begin
          state_s = FETCH;
        end
      end
      HOLD: begin
        if (redirect_valid) begin
          instr_valid_s = 1'b0;
          pc_s          = redir_tgt_s;
          addr_err_s    = redir_mis_s;
          state_s       = FETCH;
        end else if (dec_ready && !stall) begin
          instr_valid_s = 1'b0;
          state_s       = FETCH;
        end else begin
          state_s = HOLD;
        end
      end
      default: begin
        state_s = BOOT;
      end
    endcase
  end

  // Datapath registers and registered IM request/address.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pc_r          <= RESET_PC;
      kill_r        <= 1'b0;
      pend_r        <= 32'h0000_0000;
      instr_valid_r <= 1'b0;
      instr_r       <= 32'h0000_0000;
      instr_pc_r    <= 32'h0000_0000;
      addr_err_r    <= 1'b0;
      imem_req_r    <= 1'b0;
      imem_addr_r   <= RESET_PC;
    end else begin
      pc_r          <= pc_s;
      kill_r        <= kill_s;
      pend_r        <= pend_s;
      instr_valid_r <= instr_valid_s;
      instr_r       <= instr_s;
      instr_pc_r    <= instr_pc_s;
      addr_err_r    <= addr_err_s;
      imem_req_r    <= (state_s == FETCH);
      imem_addr_r   <= pc_s;
    end
  end

  assign imem_req    = imem_req_r;
  assign imem_addr   = imem_addr_r;
  assign instr_valid = instr_valid_r;
  assign instr       = instr_r;
  assign instr_pc    = instr_pc_r;
  assign pc_plus_4   = instr_pc_r + 32'd4;
  assign addr_err    = addr_err_r;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Bench for fetch_sequencer: an IM responder with programmable latency,
// expected fetch addresses and delivered instructions kept in queues.
module tb_fetch_sequencer;

  localparam logic [31:0] MASK = 32'hA5A5_0000;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        redirect_valid;
  logic [31:0] redirect_target;
  logic        dec_ready, stall;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        instr_valid;
  logic [31:0] instr, instr_pc, pc_plus_4;
  logic        addr_err;

  logic        w_reset_n, w_ack, w_req, w_valid, w_err;
  logic [31:0] w_rdata, w_addr, w_instr, w_pc, w_pc4;

  int n_checks = 0;
  int n_pass   = 0;
  int lat      = 1;
  int cnt      = 0;
  logic prev_valid = 1'b0;
  logic [31:0] exp_addr_q[$];
  logic [31:0] exp_pc_q[$];

  fetch_sequencer dut (
    .clk(clk), .reset_n(reset_n), .redirect_valid(redirect_valid),
    .redirect_target(redirect_target), .dec_ready(dec_ready), .stall(stall),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack),
    .imem_rdata(imem_rdata), .instr_valid(instr_valid), .instr(instr),
    .instr_pc(instr_pc), .pc_plus_4(pc_plus_4), .addr_err(addr_err)
  );

  fetch_sequencer #(.RESET_PC(32'hFFFF_FFFC)) dut_w (
    .clk(clk), .reset_n(w_reset_n), .redirect_valid(1'b0),
    .redirect_target(32'h0000_0000), .dec_ready(1'b1), .stall(1'b0),
    .imem_req(w_req), .imem_addr(w_addr), .imem_ack(w_ack),
    .imem_rdata(w_rdata), .instr_valid(w_valid), .instr(w_instr),
    .instr_pc(w_pc), .pc_plus_4(w_pc4), .addr_err(w_err)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, obs, exp);
  endtask

  // IM responder: acks after lat cycles of request, checks the address acked.
  always @(negedge clk) begin
    if (!reset_n) begin
      imem_ack = 1'b0;
      cnt = 0;
    end else if (imem_ack) begin
      imem_ack = 1'b0;
      cnt = 0;
    end else if (imem_req) begin
      if (cnt >= lat) begin
        imem_ack   = 1'b1;
        imem_rdata = imem_addr ^ MASK;
        check_val("im_addr_expected", 32'(exp_addr_q.size() != 0), 32'd1);
        if (exp_addr_q.size() != 0) check_val("im_addr", imem_addr, exp_addr_q.pop_front());
      end else begin
        cnt++;
      end
    end else begin
      cnt = 0;
    end
  end

  // Instruction monitor: each new valid instruction must match the next expected PC.
  always @(negedge clk) begin
    if (!reset_n) begin
      prev_valid = 1'b0;
    end else begin
      if (instr_valid && !prev_valid) begin
        check_val("instr_expected", 32'(exp_pc_q.size() != 0), 32'd1);
        if (exp_pc_q.size() != 0) begin
          logic [31:0] p;
          p = exp_pc_q.pop_front();
          check_val("instr_pc", instr_pc, p);
          check_val("instr", instr, p ^ MASK);
          check_val("pc_plus_4", pc_plus_4, p + 32'd4);
        end
      end
      prev_valid = instr_valid;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ack(input string tag);
    logic seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge clk);
      #1;
      if (imem_ack) seen = 1'b1;
    end
    check_val(tag, 32'(seen), 32'd1);
  endtask

  task automatic wait_valid_pc(input string tag, input logic [31:0] pc);
    logic seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge clk);
      #2;
      if (instr_valid && instr_pc == pc) seen = 1'b1;
    end
    check_val(tag, 32'(seen), 32'd1);
  endtask

  task automatic pulse_redirect(input logic [31:0] tgt);
    redirect_valid  = 1'b1;
    redirect_target = tgt;
    tick();
    redirect_valid  = 1'b0;
  endtask

  initial begin
    reset_n = 1'b0; w_reset_n = 1'b0;
    redirect_valid = 1'b0; redirect_target = 32'h0000_0000;
    dec_ready = 1'b1; stall = 1'b0;
    imem_ack = 1'b0; imem_rdata = 32'h0000_0000;
    w_ack = 1'b0; w_rdata = 32'h0000_0000;
    repeat (3) tick();
    check_val("rst_req", 32'(imem_req), 32'd0);
    check_val("rst_addr", imem_addr, 32'h0000_3000);
    check_val("rst_valid", 32'(instr_valid), 32'd0);
    check_val("rst_instr", instr, 32'h0000_0000);
    check_val("rst_instr_pc", instr_pc, 32'h0000_0000);
    check_val("rst_pc4", pc_plus_4, 32'h0000_0004);
    check_val("rst_err", 32'(addr_err), 32'd0);

    // T1: sequential fetch with 1-cycle IM latency
    exp_addr_q.push_back(32'h3000); exp_pc_q.push_back(32'h3000);
    exp_addr_q.push_back(32'h3004); exp_pc_q.push_back(32'h3004);
    reset_n = 1'b1;
    tick();
    check_val("boot_req", 32'(imem_req), 32'd1);
    wait_valid_pc("t1_valid_3004", 32'h3004);
    stall = 1'b1;

    // T2: stalled hold
    for (int i = 0; i < 3; i++) begin
      tick();
      check_val("t2_valid", 32'(instr_valid), 32'd1);
      check_val("t2_pc", instr_pc, 32'h3004);
      check_val("t2_instr", instr, 32'h3004 ^ MASK);
      check_val("t2_req", 32'(imem_req), 32'd0);
    end
    exp_addr_q.push_back(32'h3008);
    stall = 1'b0;

    // T3: redirect coinciding with the ack for 0x3008
    wait_ack("t3_ack");
    exp_addr_q.push_back(32'h3100); exp_pc_q.push_back(32'h3100);
    pulse_redirect(32'h3100);
    check_val("t3_addr", imem_addr, 32'h3100);
    check_val("t3_req", 32'(imem_req), 32'd1);
    check_val("t3_valid", 32'(instr_valid), 32'd0);
    wait_valid_pc("t3_valid_3100", 32'h3100);

    // T4: two redirects while a 4-cycle fetch is outstanding
    lat = 4;
    exp_addr_q.push_back(32'h3104);
    tick();
    check_val("t4_addr0", imem_addr, 32'h3104);
    pulse_redirect(32'h3200);
    check_val("t4_addr1", imem_addr, 32'h3104);
    pulse_redirect(32'h3300);
    check_val("t4_addr2", imem_addr, 32'h3104);
    exp_addr_q.push_back(32'h3300); exp_pc_q.push_back(32'h3300);
    wait_ack("t4_ack");
    lat = 1;
    tick();
    check_val("t4_addr_new", imem_addr, 32'h3300);
    check_val("t4_valid", 32'(instr_valid), 32'd0);
    wait_valid_pc("t4_valid_3300", 32'h3300);

    // T5: misaligned redirect in HOLD
    exp_addr_q.push_back(32'h3400); exp_pc_q.push_back(32'h3400);
    pulse_redirect(32'h3402);
    check_val("t5_err", 32'(addr_err), 32'd1);
    check_val("t5_valid", 32'(instr_valid), 32'd0);
    check_val("t5_addr", imem_addr, 32'h3400);
    check_val("t5_req", 32'(imem_req), 32'd1);
    tick();
    check_val("t5_err_pulse", 32'(addr_err), 32'd0);
    wait_valid_pc("t5_valid_3400", 32'h3400);
    stall = 1'b1;
    check_val("q_addr_empty", 32'(exp_addr_q.size()), 32'd0);
    check_val("q_pc_empty", 32'(exp_pc_q.size()), 32'd0);

    // Reset in the middle of a fetch
    lat = 4;
    stall = 1'b0;
    tick();
    check_val("mid_req", 32'(imem_req), 32'd1);
    check_val("mid_addr", imem_addr, 32'h3404);
    tick();
    reset_n = 1'b0;
    #1;
    check_val("mid_rst_req", 32'(imem_req), 32'd0);
    check_val("mid_rst_addr", imem_addr, 32'h3000);
    check_val("mid_rst_valid", 32'(instr_valid), 32'd0);
    check_val("mid_rst_pc", instr_pc, 32'h0000_0000);
    check_val("mid_rst_pc4", pc_plus_4, 32'h0000_0004);
    repeat (2) tick();
    lat = 1;
    exp_addr_q.push_back(32'h3000); exp_pc_q.push_back(32'h3000);
    reset_n = 1'b1;
    wait_valid_pc("rerst_valid_3000", 32'h3000);
    stall = 1'b1;
    check_val("q_addr_empty2", 32'(exp_addr_q.size()), 32'd0);

    // T6: PC wrap at the top of the address space
    w_reset_n = 1'b1;
    tick();
    check_val("t6_req", 32'(w_req), 32'd1);
    check_val("t6_addr", w_addr, 32'hFFFF_FFFC);
    w_ack = 1'b1; w_rdata = 32'h1234_5678;
    tick();
    w_ack = 1'b0;
    check_val("t6_valid", 32'(w_valid), 32'd1);
    check_val("t6_instr", w_instr, 32'h1234_5678);
    check_val("t6_pc", w_pc, 32'hFFFF_FFFC);
    check_val("t6_pc4", w_pc4, 32'h0000_0000);
    tick();
    check_val("t6_next_req", 32'(w_req), 32'd1);
    check_val("t6_next_addr", w_addr, 32'h0000_0000);
    check_val("t6_err", 32'(w_err), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
